// File: rtl/serial_adder_seq.sv
// serial_adder_seq -- bit-serial ripple adder, one bit per clock, LSB first.
//
// Each bit is added by a full-adder slice built from two half_adder_structural
// cells plus an OR for the carry-out. A carry flip-flop links successive bit
// positions. Operands are captured on an accepted Start. The result builds up
// in an internal shift register. Sum and Cout are updated only when the last
// bit completes.
//
// Ports:
//   Clk    in   rising-edge clock
//   Reset  in   asynchronous, active-high reset
//   Start  in   request; sampled in IDLE or DONE, ignored while busy
//   A, B   in   WIDTH-bit operands, captured on accepted Start
//   Cin    in   carry-in, captured on accepted Start
//   Busy   out  high while bits are being added
//   Done   out  one-cycle pulse when Sum/Cout carry a fresh result
//   Sum    out  registered WIDTH-bit result, holds until next completion
//   Cout   out  registered carry-out, holds until next completion

module half_adder_structural (
    input  logic a,
    input  logic b,
    output logic s,
    output logic c
);
    xor g_s (s, a, b);
    and g_c (c, a, b);
endmodule

module serial_adder_seq #(
    parameter int WIDTH = 8
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] Sum,
    output logic             Cout
);
    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] s_sh;
    logic             c;
    logic [CNT_W-1:0] cnt;

    // Full-adder slice: two half adders, carry-out is the OR of both carries.
    logic p, g0, g1, s_bit, c_next;

    half_adder_structural u_ha0 (.a(a_sh[0]), .b(b_sh[0]), .s(p),     .c(g0));
    half_adder_structural u_ha1 (.a(p),       .b(c),       .s(s_bit), .c(g1));

    assign c_next = g0 | g1;

    // The new bit enters at the MSB, so after WIDTH shifts bit 0 holds the LSB.
    // A single-bit register has nothing to shift down, so that case gets its
    // own branch.
    logic [WIDTH-1:0] s_sh_next;

    generate
        if (WIDTH == 1) begin : g_w1
            assign s_sh_next = s_bit;
        end else begin : g_wn
            assign s_sh_next = {s_bit, s_sh[WIDTH-1:1]};
        end
    endgenerate

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state <= IDLE;
            a_sh  <= '0;
            b_sh  <= '0;
            s_sh  <= '0;
            c     <= 1'b0;
            cnt   <= '0;
            Sum   <= '0;
            Cout  <= 1'b0;
        end else begin
            case (state)
                // DONE accepts Start exactly like IDLE, so requests can run back to back.
                IDLE, DONE: begin
                    if (Start) begin
                        a_sh  <= A;
                        b_sh  <= B;
                        c     <= Cin;
                        cnt   <= '0;
                        state <= ADD;
                    end else begin
                        state <= IDLE;
                    end
                end
                ADD: begin
                    a_sh <= a_sh >> 1;
                    b_sh <= b_sh >> 1;
                    s_sh <= s_sh_next;
                    c    <= c_next;
                    cnt  <= cnt + 1'b1;
                    // Publish only on the final bit so partial sums never appear on Sum.
                    if (cnt == LAST) begin
                        Sum   <= s_sh_next;
                        Cout  <= c_next;
                        state <= DONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign Busy = (state == ADD);
    assign Done = (state == DONE);

endmodule

// File: tb/tb_serial_adder_seq.sv
module tb_serial_adder_seq;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] a, b;
    logic         cin;
    logic         busy, done;
    logic [W-1:0] sum;
    logic         cout;

    serial_adder_seq #(.WIDTH(W)) dut (
        .Clk(clk), .Reset(rst), .Start(start), .A(a), .B(b), .Cin(cin),
        .Busy(busy), .Done(done), .Sum(sum), .Cout(cout)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int done_seen = 0;
    logic [W:0] sb_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard: every Done pops one expected {Cout,Sum}.
    always @(negedge clk) begin
        if (!rst && done) begin
            logic [W:0] e;
            done_seen++;
            tests++;
            if (sb_q.size() == 0) begin
                fails++;
                $display("FAIL sb_unexpected_done: got %0h, expected no Done", {cout, sum});
            end else begin
                e = sb_q.pop_front();
                if ({cout, sum} !== e) begin
                    fails++;
                    $display("FAIL sb_result: got %0h, expected %0h", {cout, sum}, e);
                end
            end
        end
    end

    // Called right after driving Start at a negedge. Counts negedges until Done,
    // checks Busy on each ADD cycle, releases Start after the first cycle unless held.
    task automatic wait_done(input bit hold, output int n);
        n = 0;
        while (n < 30) begin
            @(negedge clk);
            n++;
            if (!hold) start = 1'b0;
            if (done) break;
            if (!busy) begin
                tests++; fails++;
                $display("FAIL busy_low: got 0, expected 1 at cycle %0d", n);
            end
        end
        if (!done) begin
            tests++; fails++;
            $display("FAIL timeout: got no Done, expected Done within 30 cycles");
        end
    endtask

    task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tc,
                          input logic [W:0] exp, input string name);
        int n;
        a = ta; b = tb; cin = tc; start = 1'b1;
        sb_q.push_back(exp);
        wait_done(1'b0, n);
        check({name, "_latency"}, n, 9);
        check({name, "_sum"}, sum, exp[W-1:0]);
        check({name, "_cout"}, cout, exp[W]);
        @(negedge clk);
        check({name, "_done_pulse"}, done, 0);
    endtask

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
        logic [W-1:0] sum;
        logic         cout;
    } vec_t;

    vec_t vecs[7];

    initial begin
        int n, d0;
        vecs[0] = '{8'h3C, 8'h05, 1'b0, 8'h41, 1'b0};
        vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
        vecs[2] = '{8'h00, 8'h00, 1'b1, 8'h01, 1'b0};
        vecs[3] = '{8'hAA, 8'h55, 1'b1, 8'h00, 1'b1};
        vecs[4] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0};
        vecs[5] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
        vecs[6] = '{8'h12, 8'h34, 1'b0, 8'h46, 1'b0};

        rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_sum", sum, 0);
        check("reset_cout", cout, 0);

        // Table-driven vectors.
        for (int i = 0; i < 7; i++)
            run_op(vecs[i].a, vecs[i].b, vecs[i].cin, {vecs[i].cout, vecs[i].sum}, $sformatf("vec%0d", i));

        // Async reset between edges clears outputs immediately.
        run_op(8'hC0, 8'h50, 1'b0, 9'h110, "pre_reset");
        #2 rst = 1'b1;
        #1;
        check("async_rst_sum", sum, 0);
        check("async_rst_cout", cout, 1'b0);
        check("async_rst_busy", busy, 0);
        @(negedge clk);
        rst = 1'b0;

        // Start pulsed during ADD must be ignored.
        d0 = done_seen;
        a = 8'h10; b = 8'h20; cin = 1'b0; start = 1'b1;
        sb_q.push_back(9'h030);
        n = 0;
        while (n < 30) begin
            @(negedge clk);
            n++;
            start = 1'b0;
            if (done) break;
            if (n == 3) begin a = 8'hFF; b = 8'hFF; start = 1'b1; end
        end
        check("busy_start_latency", n, 9);
        check("busy_start_sum", sum, 8'h30);
        check("busy_start_cout", cout, 0);
        repeat (12) @(negedge clk);
        check("busy_start_one_done", done_seen - d0, 1);

        // Back-to-back with Start held high.
        a = 8'h80; b = 8'h80; cin = 1'b0; start = 1'b1;
        sb_q.push_back(9'h100);
        wait_done(1'b1, n);
        check("b2b_first_latency", n, 9);
        check("b2b_first_sum", sum, 8'h00);
        check("b2b_first_cout", cout, 1);
        a = 8'h01; b = 8'h02;
        sb_q.push_back(9'h003);
        wait_done(1'b1, n);
        start = 1'b0;
        check("b2b_second_gap", n, 9);
        check("b2b_second_sum", sum, 8'h03);
        check("b2b_second_cout", cout, 0);
        @(negedge clk);

        // Reset in the middle of ADD abandons the operation.
        d0 = done_seen;
        a = 8'h55; b = 8'h22; cin = 1'b0; start = 1'b1;
        repeat (4) begin @(negedge clk); start = 1'b0; end
        check("midop_busy_before", busy, 1);
        rst = 1'b1;
        #1;
        check("midop_rst_sum", sum, 0);
        check("midop_rst_cout", cout, 0);
        check("midop_rst_busy", busy, 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (12) @(negedge clk);
        check("midop_no_done", done_seen - d0, 0);
        check("midop_sum_held", sum, 0);
        run_op(8'h0F, 8'h01, 1'b0, 9'h010, "after_midop");

        check("sb_drained", sb_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish, expected finish by 200000");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/serial_adder_seq.md
Name: serial_adder_seq

Overview:
- Bit-serial ripple adder. Adds two WIDTH-bit operands one bit per clock, LSB first.
- The per-bit full-adder slice is two half_adder_structural instances plus an OR for carry-out. A carry flip-flop closes the loop between bit positions.
- Operand and result shift registers plus a start/done handshake make it a drop-in consumer of the half-adder cell for multi-bit, area-minimal addition.

Parameters:
- WIDTH, 8, operand/result width in bits; legal range 1..32.
- CNT_W, $clog2(WIDTH+1), bit-counter width; derived, not overridden.

Ports:
- Clk  input  1  rising-edge clock.
- Reset  input  1  asynchronous, active-high reset.
- Start  input  1  request; sampled on rising Clk when in IDLE or DONE.
- A  input  WIDTH  operand A; captured on accepted Start.
- B  input  WIDTH  operand B; captured on accepted Start.
- Cin  input  1  carry-in; captured on accepted Start.
- Busy  output  1  high while in ADD state.
- Done  output  1  one-cycle pulse when result is valid.
- Sum  output  WIDTH  registered result; holds until next completion.
- Cout  output  1  registered carry-out; holds until next completion.

Interface decision: one clock (Clk); reset (Reset) is asynchronous and active-high.

Behaviour:
- Reset (async assert, any state, including mid-operation):
  - State=IDLE; Busy=0, Done=0, Sum=0, Cout=0.
  - Internal shift registers, carry flop and counter cleared.
  - An in-flight operation is abandoned; no Done is produced.
- States: IDLE, ADD, DONE. All registered; Busy and Done are decoded from the state register.
- IDLE:
  - Start=1 at edge k: load a_sh<=A, b_sh<=B, c<=Cin, cnt<=0 → ADD.
  - Start=0: stay.
- ADD (edges k+1 .. k+WIDTH, one bit per edge):
  - s = a_sh[0]^b_sh[0]^c; c <= majority(a_sh[0], b_sh[0], c).
  - a_sh, b_sh shift right, zero-fill at MSB.
  - s_sh <= {s, s_sh[WIDTH-1:1]}; cnt <= cnt+1.
  - On the edge where cnt==WIDTH-1: Sum <= final s_sh contents including this edge's bit; Cout <= new carry → DONE.
  - Start ignored throughout ADD; operands are not re-captured.
- DONE (exactly one cycle): Done=1, Busy=0.
  - Start=1: behaves exactly as IDLE-accept (back-to-back operation) → ADD.
  - Start=0: → IDLE.
- Latency: Start sampled at edge k; Done high in the cycle after edge k+WIDTH; Sum/Cout valid from the same edge.
- Throughput: one result per WIDTH+1 cycles.
- Sum/Cout change only on the ADD→DONE edge or on reset. Partial sums are never visible on Sum.
- Arithmetic: {Cout,Sum} == A+B+Cin, modulo 2^(WIDTH+1). Wrap-around is expressed solely through Cout.
- A, B and Cin changing after capture have no effect on the running operation.
- WIDTH=1: ADD lasts one edge; Done one cycle after the ADD edge.

Test Plan (WIDTH=8, reset pulsed first):
- Reset check: Reset=1 async between edges → Busy=0, Done=0, Sum=8'h00, Cout=0 immediately, before the next edge.
- Basic add: A=8'h3C, B=8'h05, Cin=0, Start 1 cycle → Busy for 8 cycles; Done pulses once, 9 cycles after the Start edge; Sum=8'h41, Cout=0.
- Overflow wrap: A=8'hFF, B=8'h01, Cin=0 → Sum=8'h00, Cout=1. Also A=8'h00, B=8'h00, Cin=1 → Sum=8'h01, Cout=0.
- Start during Busy: start A=8'h10, B=8'h20; pulse Start with A=8'hFF, B=8'hFF at cycle 3 → result still 8'h30, Cout=0; only one Done.
- Back-to-back: hold Start=1 with A=8'h80, B=8'h80 then A=8'h01, B=8'h02 applied in the Done cycle → first Done: Sum=8'h00, Cout=1; second Done exactly 9 cycles later: Sum=8'h03, Cout=0.
- Reset mid-op: assert Reset at cycle 4 of ADD → no Done; Sum/Cout=0. Next Start with A=8'h0F, B=8'h01 → Sum=8'h10 after 9 cycles.
